// File: rtl/response_frame_tx_if.sv
// Handshake bundle between the response framer, the response FIFO and the UART transmitter.
interface response_frame_tx_if #(
    parameter int WORD_BITS = 32,
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic                 fifo_empty;
    logic [WORD_BITS-1:0] fifo_dout;
    logic                 fifo_re;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_enable;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, fifo_empty, fifo_dout, tx_busy,
        output fifo_re, tx_data, tx_enable, busy, done
    );

    modport slave (
        output start, fifo_empty, fifo_dout, tx_busy,
        input  fifo_re, tx_data, tx_enable, busy, done
    );
endinterface

// File: rtl/response_frame_tx.sv
// Response framer: header, 16-bit word count, then NUM_WORDS FIFO words sent MSB byte first over UART.
// Optional trailing XOR checksum byte when RESP_FRAME_CHECKSUM_EN is defined.
module response_frame_tx #(
    parameter int         WORD_BITS   = 32,
    parameter int         DATA_BITS   = 8,
    parameter int         NUM_WORDS   = 40,
    parameter logic [7:0] RESPONSE_ID = 8'b10101011
) (
    input logic               clk,
    input logic               reset,
    response_frame_tx_if.master bus
);
    localparam int BYTES  = WORD_BITS / DATA_BITS;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
    localparam logic [15:0]       LAST_WORD = 16'(NUM_WORDS - 1);
    localparam logic [15:0]       COUNT     = 16'(NUM_WORDS);

    typedef enum logic [2:0] {
        IDLE, LOAD_BYTE, SEND, WAIT_HI, WAIT_LO, FETCH, LATCH, DONE
    } state_t;

    typedef enum logic [2:0] {
        F_HDR, F_CNT_HI, F_CNT_LO, F_PAYLOAD, F_CSUM
    } field_t;

    state_t               state, state_nx;
    field_t               field;
    logic [WORD_BITS-1:0] shreg;
    logic [BIDX_W-1:0]    byte_idx;
    logic [15:0]          word_cnt;
    logic [DATA_BITS-1:0] tx_data_q;
    logic                 tx_enable_q;
    logic                 fifo_re_c;
    logic                 last_byte;
    logic                 last_word;
    logic [DATA_BITS-1:0] next_byte;
`ifdef RESP_FRAME_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign last_byte = (byte_idx == LAST_BYTE);
    assign last_word = (word_cnt == LAST_WORD);

    always_comb begin
        next_byte = '0;
        case (field)
            F_CNT_HI:  next_byte = DATA_BITS'(COUNT[15:8]);
            F_CNT_LO:  next_byte = DATA_BITS'(COUNT[7:0]);
            F_PAYLOAD: next_byte = shreg[WORD_BITS-1 -: DATA_BITS];
`ifdef RESP_FRAME_CHECKSUM_EN
            F_CSUM:    next_byte = DATA_BITS'(csum);
`endif
            default:   next_byte = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        fifo_re_c = 1'b0;
        case (state)
            IDLE:      if (bus.start) state_nx = SEND;
            LOAD_BYTE: state_nx = SEND;
            SEND:      if (!bus.tx_busy) state_nx = WAIT_HI;
            WAIT_HI:   if (bus.tx_busy) state_nx = WAIT_LO;
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    case (field)
                        F_HDR, F_CNT_HI: state_nx = LOAD_BYTE;
                        F_CNT_LO:        state_nx = FETCH;
                        F_PAYLOAD: begin
                            if (!last_byte)      state_nx = LOAD_BYTE;
                            else if (!last_word) state_nx = FETCH;
                            else begin
`ifdef RESP_FRAME_CHECKSUM_EN
                                state_nx = LOAD_BYTE;
`else
                                state_nx = DONE;
`endif
                            end
                        end
                        default:         state_nx = DONE;
                    endcase
                end
            end
            FETCH: begin
                if (!bus.fifo_empty) begin
                    fifo_re_c = 1'b1;
                    state_nx  = LATCH;
                end
            end
            LATCH:   state_nx = LOAD_BYTE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Field/byte/word bookkeeping advances only when a byte has fully left the UART.
    always_ff @(posedge clk) begin
        if (reset) begin
            field       <= F_HDR;
            shreg       <= '0;
            byte_idx    <= '0;
            word_cnt    <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
`ifdef RESP_FRAME_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            tx_enable_q <= (state == SEND) && !bus.tx_busy;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx_data_q <= DATA_BITS'(RESPONSE_ID);
                        field     <= F_HDR;
                        byte_idx  <= '0;
                        word_cnt  <= '0;
`ifdef RESP_FRAME_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                LOAD_BYTE: begin
                    tx_data_q <= next_byte;
`ifdef RESP_FRAME_CHECKSUM_EN
                    if (field != F_CSUM) csum <= csum ^ 8'(next_byte);
`endif
                end
                LATCH: shreg <= bus.fifo_dout;
                WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        case (field)
                            F_HDR:    field <= F_CNT_HI;
                            F_CNT_HI: field <= F_CNT_LO;
                            F_CNT_LO: field <= F_PAYLOAD;
                            F_PAYLOAD: begin
                                if (last_byte) begin
                                    byte_idx <= '0;
                                    if (last_word) field <= F_CSUM;
                                    else           word_cnt <= word_cnt + 16'd1;
                                end else begin
                                    byte_idx <= byte_idx + 1'b1;
                                    shreg    <= shreg << DATA_BITS;
                                end
                            end
                            default: field <= field;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fifo_re   = fifo_re_c;
    assign bus.tx_enable = tx_enable_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = (state != IDLE) && (state != DONE);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_response_frame_tx.sv
// Directed bench for response_frame_tx: FIFO and 10-cycle UART models, hand-computed frame bytes.
module tb_response_frame_tx;
    localparam int WB = 32;
    localparam int DB = 8;
`ifdef RESP_FRAME_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    response_frame_tx_if #(.WORD_BITS(WB), .DATA_BITS(DB)) ifa ();
    response_frame_tx_if #(.WORD_BITS(WB), .DATA_BITS(DB)) ifb ();

    response_frame_tx #(.WORD_BITS(WB), .DATA_BITS(DB), .NUM_WORDS(2), .RESPONSE_ID(8'hAB))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
    response_frame_tx #(.WORD_BITS(WB), .DATA_BITS(DB), .NUM_WORDS(1), .RESPONSE_ID(8'hAB))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

    logic          start_a = 1'b0, start_b = 1'b0;
    logic          hold_busy = 1'b0, hold_empty = 1'b0, sel = 1'b0;
    logic [WB-1:0] fifo_dout = '0;
    logic [WB-1:0] fifo_mem [0:15];
    int            wr_ptr = 0, rd_ptr = 0, uart_cnt = 0, cyc = 0;
    logic          tx_busy, fifo_empty;

    assign tx_busy    = (uart_cnt != 0) || hold_busy;
    assign fifo_empty = hold_empty || (rd_ptr == wr_ptr);

    assign ifa.start = start_a;  assign ifa.tx_busy = tx_busy;
    assign ifa.fifo_empty = fifo_empty;  assign ifa.fifo_dout = fifo_dout;
    assign ifb.start = start_b;  assign ifb.tx_busy = tx_busy;
    assign ifb.fifo_empty = fifo_empty;  assign ifb.fifo_dout = fifo_dout;

    logic          m_tx_enable, m_fifo_re, m_done, m_busy;
    logic [DB-1:0] m_tx_data;
    assign m_tx_enable = sel ? ifb.tx_enable : ifa.tx_enable;
    assign m_fifo_re   = sel ? ifb.fifo_re   : ifa.fifo_re;
    assign m_done      = sel ? ifb.done      : ifa.done;
    assign m_busy      = sel ? ifb.busy      : ifa.busy;
    assign m_tx_data   = sel ? ifb.tx_data   : ifa.tx_data;

    // UART busy for 10 cycles per byte; FIFO data appears the cycle after fifo_re.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_tx_enable)        uart_cnt <= 10;
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
        if (m_fifo_re && rd_ptr != wr_ptr) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [7:0] rx [0:127];
    logic [7:0] last_tx = '0;
    logic       prev_busy = 1'b0;
    int rx_n = 0, n_en = 0, n_re = 0, n_done = 0, stab_err = 0, dup_err = 0, fall_cyc = 0;

    always @(negedge clk) begin
        prev_busy <= tx_busy;
        if (prev_busy && !tx_busy) fall_cyc <= cyc;
        if (m_tx_enable) begin
            rx[rx_n] <= m_tx_data;
            rx_n     <= rx_n + 1;
            n_en     <= n_en + 1;
            last_tx  <= m_tx_data;
            if (uart_cnt != 0) dup_err <= dup_err + 1;
        end
        if (m_fifo_re) n_re <= n_re + 1;
        if (m_done) n_done <= n_done + 1;
        if (uart_cnt != 0 && m_busy && !m_tx_enable && m_tx_data != last_tx) stab_err <= stab_err + 1;
    end

    int n_vec = 0, n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_fifo(input logic [WB-1:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!m_done && k < budget) begin
            tick();
            k++;
        end
        check_eq({tag, "_done_seen"}, 32'(m_done), 1);
    endtask

    task automatic wait_rx(input string tag, input int base, input int cnt);
        int k = 0;
        while ((rx_n - base) < cnt && k < 400) begin
            tick();
            k++;
        end
        check_eq({tag, "_rx_reached"}, 32'(rx_n - base >= cnt), 1);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [127:0] v,
                               input int len, input logic [7:0] cs);
        check_eq({tag, "_len"}, 32'(rx_n - base), 32'(len + CS));
        for (int i = 0; i < len; i++)
            check_eq($sformatf("%s_b%0d", tag, i), 32'(rx[base + i]), 32'(v[8*(len-1-i) +: 8]));
        if (CS != 0)
            check_eq({tag, "_csum"}, 32'(rx[base + len]), 32'(cs));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_tx_enable"}, 32'(ifa.tx_enable), 0);
        check_eq({tag, "_fifo_re"},   32'(ifa.fifo_re), 0);
        check_eq({tag, "_busy"},      32'(ifa.busy), 0);
        check_eq({tag, "_done"},      32'(ifa.done), 0);
        check_eq({tag, "_tx_data"},   32'(ifa.tx_data), 0);
    endtask

    localparam logic [127:0] FRAME_A = 128'(88'hAB_0002_DEADBEEF_01234567);

    initial begin
        int base, re0, en0, d0, k;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick();
        check_idle_outputs("rst");

        // Basic two-word frame and header latency
        load_fifo(32'hDEADBEEF); load_fifo(32'h01234567);
        base = rx_n; re0 = n_re; d0 = n_done;
        start_a = 1'b1;
        tick();
        check_eq("t1_busy_after_start", 32'(ifa.busy), 1);
        check_eq("t1_no_early_enable", 32'(ifa.tx_enable), 0);
        start_a = 1'b0;
        tick();
        check_eq("t1_hdr_latency", 32'(ifa.tx_enable), 1);
        check_eq("t1_hdr_data", 32'(ifa.tx_data), 32'hAB);
        wait_done("t1", 400);
        tick();
        check_frame("t1", base, FRAME_A, 11, 8'h20);
        check_eq("t1_reads", 32'(n_re - re0), 2);
        check_eq("t1_dones", 32'(n_done - d0), 1);
        check_eq("t1_busy_low", 32'(ifa.busy), 0);

        // Empty FIFO stall after the count bytes
        load_fifo(32'hDEADBEEF); load_fifo(32'h01234567);
        hold_empty = 1'b1;
        base = rx_n; re0 = n_re;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_rx("t2", base, 3);
        k = 0;
        while (tx_busy && k < 50) begin tick(); k++; end
        en0 = n_en;
        tick(50);
        check_eq("t2_stall_reads", 32'(n_re - re0), 0);
        check_eq("t2_stall_enables", 32'(n_en - en0), 0);
        check_eq("t2_stall_busy", 32'(ifa.busy), 1);
        hold_empty = 1'b0;
        wait_done("t2", 400);
        tick();
        check_frame("t2", base, FRAME_A, 11, 8'h20);
        check_eq("t2_reads", 32'(n_re - re0), 2);

        // UART busy around start; starts mid-frame and coincident with done ignored
        load_fifo(32'hDEADBEEF); load_fifo(32'h01234567);
        hold_busy = 1'b1;
        tick(5);
        base = rx_n; re0 = n_re; en0 = n_en; d0 = n_done;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(15);
        check_eq("t3_held_enables", 32'(n_en - en0), 0);
        check_eq("t3_held_busy", 32'(ifa.busy), 1);
        hold_busy = 1'b0;
        wait_rx("t3", base, 5);
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done("t3", 400);
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(40);
        check_frame("t3", base, FRAME_A, 11, 8'h20);
        check_eq("t3_reads", 32'(n_re - re0), 2);
        check_eq("t3_dones", 32'(n_done - d0), 1);
        check_eq("t3_enables", 32'(n_en - en0), 32'(11 + CS));
        check_eq("t3_busy_low", 32'(ifa.busy), 0);

        // Reset during the second payload byte, then a fresh frame
        load_fifo(32'hDEADBEEF); load_fifo(32'h01234567);
        base = rx_n; re0 = n_re;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_rx("t4", base, 5);
        reset = 1'b1;
        tick();
        check_idle_outputs("t4_rst");
        reset = 1'b0;
        en0 = n_en;
        k = 0;
        while (tx_busy && k < 50) begin tick(); k++; end
        tick(3);
        check_eq("t4_abort_enables", 32'(n_en - en0), 0);
        check_eq("t4_abort_reads", 32'(n_re - re0), 1);
        load_fifo(32'hCAFEF00D);
        base = rx_n;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done("t4", 400);
        tick();
        check_frame("t4", base, 128'(88'hAB_0002_01234567_CAFEF00D), 11, 8'hCB);
        check_eq("t4_reads", 32'(n_re - re0), 3);
        check_eq("t4_fifo_drained", 32'(fifo_empty), 1);

        // Single-word instance, zero payload, done one cycle after last busy fall
        sel = 1'b1;
        tick();
        load_fifo(32'h00000000);
        base = rx_n; re0 = n_re;
        start_b = 1'b1; tick(); start_b = 1'b0;
        wait_done("t5", 300);
        check_eq("t5_done_latency", 32'(cyc - fall_cyc), 1);
        tick();
        check_frame("t5", base, 128'(56'hAB_0001_00000000), 7, 8'h01);
        check_eq("t5_reads", 32'(n_re - re0), 1);
        check_eq("t5_busy_low", 32'(ifb.busy), 0);

        check_eq("tx_data_stability", 32'(stab_err), 0);
        check_eq("enable_while_busy", 32'(dup_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end
endmodule
